// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush sequencer: load-use bubbles, branch squash, and
// freezing IF/ID/EX while the multi-cycle M-extension unit runs in EX.
module pipeline_hazard_controller #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic [4:0] EX_rd,
  input  logic       EX_memread,
  input  logic       EX_md_valid,
  input  logic       EX_is_div,
  input  logic       branch_taken_EX,
  output logic       stall_IF,
  output logic       stall_ID,
  output logic       stall_EX,
  output logic       flush_ID,
  output logic       flush_EX,
  output logic       flush_MEM,
  output logic       md_start,
  output logic       md_result_valid,
  output logic       md_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_md_stall;
  logic w_load_use;
  logic w_branch;
  logic w_lu_stall;

  // The start cycle counts as the first stall cycle, so RUN lasts N-1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (EX_md_valid) begin
            r_cnt   <= EX_is_div ? LP_DIV_LOAD : LP_MUL_LOAD;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_md_stall = ((r_state == ST_IDLE) & EX_md_valid) | (r_state == ST_RUN);
    w_load_use = EX_memread & (EX_rd != 5'd0) &
                 ((ID_uses_rs1 & (ID_rs1 == EX_rd)) | (ID_uses_rs2 & (ID_rs2 == EX_rd)));
    // A taken branch makes the ID instruction wrong-path, so it outranks load-use.
    w_branch   = branch_taken_EX & ~w_md_stall;
    w_lu_stall = w_load_use & ~w_md_stall & ~branch_taken_EX;
  end

  // Outputs are forced low while rst is held, even though inputs may be active.
  always_comb begin
    stall_IF        = ~rst & (w_md_stall | w_lu_stall);
    stall_ID        = ~rst & (w_md_stall | w_lu_stall);
    stall_EX        = ~rst & w_md_stall;
    flush_ID        = ~rst & w_branch;
    flush_EX        = ~rst & (w_branch | w_lu_stall);
    flush_MEM       = ~rst & w_md_stall;
    md_start        = ~rst & (r_state == ST_IDLE) & EX_md_valid;
    md_result_valid = (r_state == ST_DONE);
    md_busy         = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a cycle model of the hazard
// rules checked every cycle, plus hand-computed literal expectations.
module tb_pipeline_hazard_controller;

  localparam int MUL_N = 2;
  localparam int DIV_N = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
  logic       ID_uses_rs1 = 1'b0, ID_uses_rs2 = 1'b0;
  logic       EX_memread = 1'b0, EX_md_valid = 1'b0, EX_is_div = 1'b0;
  logic       branch_taken_EX = 1'b0;
  logic       stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, flush_MEM;
  logic       md_start, md_result_valid, md_busy;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_rd(EX_rd), .EX_memread(EX_memread),
    .EX_md_valid(EX_md_valid), .EX_is_div(EX_is_div),
    .branch_taken_EX(branch_taken_EX),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
    .md_start(md_start), .md_result_valid(md_result_valid), .md_busy(md_busy)
  );

  wire [8:0] w_out = {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX,
                      flush_MEM, md_start, md_result_valid, md_busy};

  int checks = 0;
  int errors = 0;

  task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: op_pos = cycles the current M op has already spent in EX (-1 = none).
  int op_pos = -1;
  int op_len = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      op_pos = -1;
    end else if (op_pos < 0) begin
      if (EX_md_valid) begin
        op_pos = 1;
        op_len = EX_is_div ? DIV_N : MUL_N;
      end
    end else if (op_pos < op_len) begin
      op_pos = op_pos + 1;
    end else begin
      op_pos = -1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [8:0] e;
    logic idle, run, done, mds, lu, br, lus;
    idle = (op_pos < 0);
    run  = (op_pos >= 1) && (op_pos < op_len);
    done = (op_pos > 0) && (op_pos == op_len);
    mds  = (idle && EX_md_valid) || run;
    lu   = EX_memread && (EX_rd != 5'd0) &&
           ((ID_uses_rs1 && ID_rs1 == EX_rd) || (ID_uses_rs2 && ID_rs2 == EX_rd));
    br   = branch_taken_EX && !mds;
    lus  = lu && !mds && !branch_taken_EX;
    if (rst) e = '0;
    else e = {mds || lus, mds || lus, mds, br, br || lus, mds,
              idle && EX_md_valid, done, !idle};
    chk9("model_cycle", w_out, e);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic mv, input logic dv, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic br);
    EX_md_valid = mv; EX_is_div = dv; EX_memread = mr; EX_rd = rd;
    ID_rs1 = r1; ID_rs2 = r2; ID_uses_rs1 = u1; ID_uses_rs2 = u2;
    branch_taken_EX = br;
  endtask

  initial begin
    int nst, nfm, rvcyc, nrv;
    repeat (3) tick;
    mid;
    chk9("reset_outputs", w_out, 9'b0);
    tick;
    rst = 1'b0;
    tick;

    // MUL, 2 cycles
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mid;
    chk1("mul_c0_start", md_start, 1'b1);
    chk1("mul_c0_stall_ex", stall_EX, 1'b1);
    chk1("mul_c0_busy", md_busy, 1'b0);
    tick; mid;
    chk1("mul_c1_start", md_start, 1'b0);
    chk1("mul_c1_stall_ex", stall_EX, 1'b1);
    chk1("mul_c1_busy", md_busy, 1'b1);
    tick; mid;
    chk1("mul_c2_stall_ex", stall_EX, 1'b0);
    chk1("mul_c2_result", md_result_valid, 1'b1);
    chk1("mul_c2_busy", md_busy, 1'b1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid;
    chk1("mul_after_busy", md_busy, 1'b0);
    tick;

    // DIV, 33 cycles, then a second DIV with no gap
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    nst = 0; nfm = 0; rvcyc = -1;
    for (int k = 0; k < 34; k++) begin
      mid;
      nst += stall_EX ? 1 : 0;
      nfm += flush_MEM ? 1 : 0;
      if (md_result_valid) rvcyc = k;
      tick;
    end
    chkn("div_stall_cycles", nst, 33);
    chkn("div_flush_mem_cycles", nfm, 33);
    chkn("div_result_cycle", rvcyc, 33);
    mid;
    chk1("div2_start_no_gap", md_start, 1'b1);
    for (int k = 0; k < 33; k++) tick;
    mid;
    chk1("div2_result", md_result_valid, 1'b1);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid;
    tick;

    // Load-use
    set_in(0, 0, 1, 5'd5, 0, 5'd5, 0, 1, 0);
    mid;
    chk9("lu_rs2_hit", w_out, 9'b110010000);
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid;
    chk9("lu_bubble_clear", w_out, 9'b0);
    tick;
    set_in(0, 0, 1, 5'd0, 0, 5'd0, 0, 1, 0);
    mid;
    chk9("lu_x0_none", w_out, 9'b0);
    tick;
    set_in(0, 0, 1, 5'd5, 0, 5'd5, 0, 0, 0);
    mid;
    chk9("lu_unused_rs2_none", w_out, 9'b0);
    tick;
    set_in(0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 1, 0);
    mid;
    chk9("lu_rs1_hit", w_out, 9'b110010000);
    tick;

    // Branch beats load-use
    set_in(0, 0, 1, 5'd5, 0, 5'd5, 0, 1, 1);
    mid;
    chk9("branch_over_lu", w_out, 9'b000110000);
    tick;

    // Branch during M start: M stall wins
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1);
    mid;
    chk9("md_over_branch", w_out, 9'b111001100);
    tick;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;

    // Async reset in the middle of a DIV (cnt reaches 10 in cycle 23)
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (23) tick;
    chk1("div_mid_busy", md_busy, 1'b1);
    #1 rst = 1'b1;
    #1 chk9("rst_async_zero", w_out, 9'b0);
    tick;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nrv = 0;
    for (int k = 0; k < 6; k++) begin
      mid;
      nrv += (md_result_valid || md_busy) ? 1 : 0;
      tick;
    end
    chkn("post_rst_no_result", nrv, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mid;
    chk1("post_rst_fresh_start", md_start, 1'b1);
    tick;
    tick;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
